b_dly_ctrl_fc: RTL and testbench

Parametrised delay-code controller for the fine/coarse digital delay line. It accepts a target delay code through a valid/ready handshake and moves the current code to that target in one of two ways: one unit step every STEP_DIV cycles (slew mode), or in a single cycle (jump mode). It then waits a settle interval before signalling completion. It sits between the calibration/CSR logic and the delay line, and directly drives the fine thermometer select and the coarse one-hot select.

---
 rtl/b_dly_ctrl_pkg.sv | 29 ++
 rtl/b_dly_ctrl_fc_code2sel.sv | 34 +++
 rtl/b_dly_ctrl_fc.sv | 144 ++++++++++++++
 tb/tb_b_dly_ctrl_fc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/b_dly_ctrl_pkg.sv
// Shared types and constants for the fine/coarse delay-code controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package b_dly_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SLEW   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Default geometry of the delay line this controller was built for.
  localparam int FINE_BITS_DEF   = 6;
  localparam int COARSE_BITS_DEF = 3;
  localparam int CW              = FINE_BITS_DEF + COARSE_BITS_DEF;
  localparam int NFINE           = 2 ** FINE_BITS_DEF;
  localparam int NCOARSE         = 2 ** COARSE_BITS_DEF;

  localparam logic MODE_SLEW = 1'b0;
  localparam logic MODE_JUMP = 1'b1;

  // Width of the shared down-counter: must hold max(a, b) - 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/b_dly_ctrl_fc_code2sel.sv
// Decodes a delay code into fine thermometer select and coarse one-hot select.
// Latency: combinational; the parent registers the result alongside the code.
// Backpressure: none.
// Ports: code (coarse in upper bits, fine in lower bits) -> sel_fine, sel_coarse.
module b_dly_ctrl_fc_code2sel #(
  parameter int FINE_BITS   = 6,
  parameter int COARSE_BITS = 3
) (
  input  logic [FINE_BITS+COARSE_BITS-1:0] code,
  output logic [2**FINE_BITS-1:0]          sel_fine,
  output logic [2**COARSE_BITS-1:0]        sel_coarse
);

  localparam int CWL = FINE_BITS + COARSE_BITS;

  logic [FINE_BITS-1:0]   fine;
  logic [COARSE_BITS-1:0] coarse;

  assign fine   = code[FINE_BITS-1:0];
  assign coarse = code[CWL-1:FINE_BITS];

  always_comb begin
    sel_fine   = '0;
    sel_coarse = '0;
    // Thermometer: bit i set for every tap below the fine code.
    for (int i = 0; i < 2**FINE_BITS; i++) begin
      sel_fine[i] = (i < int'(fine));
    end
    for (int i = 0; i < 2**COARSE_BITS; i++) begin
      sel_coarse[i] = (i == int'(coarse));
    end
  end

endmodule

// File: rtl/b_dly_ctrl_fc.sv
// Moves the applied delay code to a requested target (slew or jump), then settles.
// Latency: jump/equal = SETTLE_CYC cycles to o_done; slew = N*STEP_DIV + SETTLE_CYC; +1 per i_hold cycle.
// Backpressure: o_tgt_rdy high only in IDLE; targets offered while busy wait (or are ignored if withdrawn).
// Ports: i_clk/i_rst, target handshake (i_tgt_vld/o_tgt_rdy/i_tgt_code/i_mode), i_hold,
//        o_code plus its decoded selects o_sel_fine/o_sel_coarse, o_busy, o_done.
module b_dly_ctrl_fc
  import b_dly_ctrl_pkg::*;
#(
  parameter int FINE_BITS   = FINE_BITS_DEF,
  parameter int COARSE_BITS = COARSE_BITS_DEF,
  parameter int STEP_DIV    = 4,
  parameter int SETTLE_CYC  = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_tgt_vld,
  output logic                             o_tgt_rdy,
  input  logic [FINE_BITS+COARSE_BITS-1:0] i_tgt_code,
  input  logic                             i_mode,
  input  logic                             i_hold,
  output logic [FINE_BITS+COARSE_BITS-1:0] o_code,
  output logic [2**FINE_BITS-1:0]          o_sel_fine,
  output logic [2**COARSE_BITS-1:0]        o_sel_coarse,
  output logic                             o_busy,
  output logic                             o_done
);

  localparam int L_CW      = FINE_BITS + COARSE_BITS;
  localparam int L_NFINE   = 2 ** FINE_BITS;
  localparam int L_NCOARSE = 2 ** COARSE_BITS;
  localparam int CNT_W     = cnt_width(STEP_DIV, SETTLE_CYC);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_t                 state_q, state_d;
  logic [L_CW-1:0]        code_q, code_d;
  logic [L_CW-1:0]        tgt_q, tgt_d;
  logic [L_CW-1:0]        step_code;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rdy_d, busy_d, done_d;
  logic [L_NFINE-1:0]     sel_fine_d;
  logic [L_NCOARSE-1:0]   sel_coarse_d;

  // One unit toward the target; the code space is linear across coarse
  // boundaries and slewing stops on the target, so no wrap can occur.
  assign step_code = (tgt_q > code_q) ? code_q + L_CW'(1) : code_q - L_CW'(1);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath next values. One down-counter serves as the
  // step divider in SLEW and the settle timer in SETTLE.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_tgt_vld) begin
          tgt_d = i_tgt_code;
          if (i_tgt_code == code_q) begin
            state_d = SETTLE;
            cnt_d   = SET_LOAD;
          end else if (i_mode == MODE_JUMP) begin
            code_d  = i_tgt_code;
            state_d = SETTLE;
            cnt_d   = SET_LOAD;
          end else begin
            state_d = SLEW;
            cnt_d   = DIV_LOAD;
          end
        end
      end
      SLEW: begin
        if (!i_hold) begin
          if (cnt_q == '0) begin
            code_d = step_code;
            cnt_d  = DIV_LOAD;
            if (step_code == tgt_q) begin
              state_d = SETTLE;
              cnt_d   = SET_LOAD;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      SETTLE: begin
        if (!i_hold) begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values, registered below together with the code.
  always_comb begin
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
    done_d = (state_q == SETTLE) && (state_d == IDLE);
  end

  // Decode from the next code so the registered selects match o_code.
  b_dly_ctrl_fc_code2sel #(
    .FINE_BITS   (FINE_BITS),
    .COARSE_BITS (COARSE_BITS)
  ) u_dly_code2sel (
    .code       (code_d),
    .sel_fine   (sel_fine_d),
    .sel_coarse (sel_coarse_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      code_q       <= '0;
      tgt_q        <= '0;
      cnt_q        <= '0;
      o_sel_fine   <= '0;
      o_sel_coarse <= L_NCOARSE'(1);
      o_tgt_rdy    <= 1'b1;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      code_q       <= code_d;
      tgt_q        <= tgt_d;
      cnt_q        <= cnt_d;
      o_sel_fine   <= sel_fine_d;
      o_sel_coarse <= sel_coarse_d;
      o_tgt_rdy    <= rdy_d;
      o_busy       <= busy_d;
      o_done       <= done_d;
    end
  end

  assign o_code = code_q;

endmodule

// File: tb/tb_b_dly_ctrl_fc.sv
module tb_b_dly_ctrl_fc;

  localparam int FB = 6;
  localparam int CB = 3;
  localparam int S  = 4;
  localparam int SC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic        rdy;
  logic [8:0]  tgt = '0;
  logic        mode = 1'b0;
  logic        hold = 1'b0;
  logic [8:0]  code;
  logic [63:0] sel_fine;
  logic [7:0]  sel_coarse;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  always #5 clk = ~clk;

  b_dly_ctrl_fc #(
    .FINE_BITS(FB), .COARSE_BITS(CB), .STEP_DIV(S), .SETTLE_CYC(SC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_tgt_vld(vld), .o_tgt_rdy(rdy),
    .i_tgt_code(tgt), .i_mode(mode), .i_hold(hold), .o_code(code),
    .o_sel_fine(sel_fine), .o_sel_coarse(sel_coarse), .o_busy(busy), .o_done(done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: an operation is a count of non-hold cycles since accept.
  // The code has moved floor(e/S) steps (capped at N), and the operation ends
  // when e reaches N*S + SC (N = 0 for jump or already-at-target).
  bit m_active = 0;
  bit m_up     = 0;
  bit m_done   = 0;
  int m_code   = 0;
  int m_start  = 0;
  int m_n      = 0;
  int m_e      = 0;

  always @(posedge clk) begin
    int k;
    if (rst) begin
      m_active = 0;
      m_code   = 0;
      m_done   = 0;
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (vld) begin
          m_active = 1;
          m_e      = 0;
          m_n      = 0;
          if (int'(tgt) != m_code) begin
            if (mode) m_code = int'(tgt);
            else begin
              m_up = int'(tgt) > m_code;
              m_n  = m_up ? int'(tgt) - m_code : m_code - int'(tgt);
            end
          end
          m_start = m_code;
        end
      end else if (!hold) begin
        m_e++;
        k = m_e / S;
        if (k > m_n) k = m_n;
        m_code = m_up ? m_start + k : m_start - k;
        if (m_e == m_n * S + SC) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    logic [63:0] ef;
    logic [7:0]  ec;
    #1;
    if (chk_en) begin
      ef = (64'd1 << (m_code % 64)) - 64'd1;
      ec = 8'd1 << (m_code / 64);
      chk("m_code", 64'(code), 64'(m_code));
      chk("m_sel_fine", sel_fine, ef);
      chk("m_sel_coarse", 64'(sel_coarse), 64'(ec));
      chk("m_rdy", 64'(rdy), 64'(!m_active));
      chk("m_busy", 64'(busy), 64'(m_active));
      chk("m_done", 64'(done), 64'(m_done));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a target for one edge; returns just after the accept edge.
  task automatic go(input int t, input bit m);
    vld  = 1'b1;
    tgt  = 9'(t);
    mode = m;
    cyc(1);
    vld  = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!rdy && n < bound) begin
      cyc(1);
      n++;
    end
    chk("idle_timeout", 64'(rdy), 64'd1);
  endtask

  initial begin
    cyc(2);
    rst    = 1'b0;
    chk_en = 1;
    // Reset defaults
    chk("rst_code", 64'(code), 64'd0);
    chk("rst_fine", sel_fine, 64'd0);
    chk("rst_coarse", 64'(sel_coarse), 64'h01);
    chk("rst_rdy", 64'(rdy), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // Slew 0 -> 3
    go(3, 0);
    cyc(1);  chk("s3_rdy_t1", 64'(rdy), 64'd0); chk("s3_busy_t1", 64'(busy), 64'd1);
    cyc(3);  chk("s3_code_t4", 64'(code), 64'd1);
    cyc(4);  chk("s3_code_t8", 64'(code), 64'd2);
    cyc(4);  chk("s3_code_t12", 64'(code), 64'd3);
    cyc(1);  chk("s3_rdy_t13", 64'(rdy), 64'd0); chk("s3_done_t13", 64'(done), 64'd0);
    cyc(1);  chk("s3_done_t14", 64'(done), 64'd1); chk("s3_rdy_t14", 64'(rdy), 64'd1);
    cyc(1);  chk("s3_done_t15", 64'(done), 64'd0);

    // Coarse crossing up and down
    go(62, 1);
    wait_idle(100);
    go(66, 0);
    cyc(4);  chk("x_code63", 64'(code), 64'd63);
    chk("x_fine63", sel_fine, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("x_coarse63", 64'(sel_coarse), 64'h01);
    cyc(4);  chk("x_code64", 64'(code), 64'd64);
    chk("x_fine64", sel_fine, 64'd0);
    chk("x_coarse64", 64'(sel_coarse), 64'h02);
    wait_idle(100);
    go(62, 0);
    cyc(4);  chk("x_down65", 64'(code), 64'd65);
    wait_idle(100);
    chk("x_down62", 64'(code), 64'd62);

    // Jump to 0x1FF, then same target again
    go(511, 1);
    chk("j_code", 64'(code), 64'd511);
    chk("j_fine", sel_fine, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("j_coarse", 64'(sel_coarse), 64'h80);
    cyc(1);  chk("j_done_t1", 64'(done), 64'd0);
    cyc(1);  chk("j_done_t2", 64'(done), 64'd1);
    go(511, 0);
    cyc(1);  chk("eq_done_t1", 64'(done), 64'd0);
    cyc(1);  chk("eq_done_t2", 64'(done), 64'd1); chk("eq_code", 64'(code), 64'd511);

    // Slew 511 -> 505 (6 steps) with 5 hold cycles mid-slew, 3 in settle,
    // and an ignored target pulse while busy: done at 26 + 8 = 34.
    go(505, 0);
    cyc(6);  hold = 1'b1;
    cyc(5);  hold = 1'b0;
    cyc(4);  vld = 1'b1; tgt = 9'd0; mode = 1'b1;
    cyc(1);  vld = 1'b0;
    cyc(13); hold = 1'b1;
    cyc(3);  hold = 1'b0;
    cyc(1);  chk("h_done_t33", 64'(done), 64'd0);
    cyc(1);  chk("h_done_t34", 64'(done), 64'd1); chk("h_code", 64'(code), 64'd505);

    // Reset mid-slew at code 40
    go(30, 1);
    wait_idle(100);
    go(50, 0);
    cyc(40); chk("r_code40", 64'(code), 64'd40);
    rst = 1'b1;
    cyc(1);  rst = 1'b0;
    chk("r_code", 64'(code), 64'd0);
    chk("r_fine", sel_fine, 64'd0);
    chk("r_coarse", 64'(sel_coarse), 64'h01);
    chk("r_rdy", 64'(rdy), 64'd1);
    chk("r_busy", 64'(busy), 64'd0);
    chk("r_done", 64'(done), 64'd0);
    cyc(3);
    go(2, 0);
    wait_idle(100);
    chk("r_after", 64'(code), 64'd2);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int cand;
      mode = 1'($urandom_range(0, 1));
      if (mode && $urandom_range(0, 3) == 0) cand = int'($urandom_range(0, 511));
      else begin
        cand = m_code + int'($urandom_range(0, 10)) - 5;
        if (cand < 0)   cand = 0;
        if (cand > 511) cand = 511;
      end
      tgt  = 9'(cand);
      vld  = ($urandom_range(0, 2) == 0);
      hold = ($urandom_range(0, 7) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    vld = 1'b0; hold = 1'b0; rst = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
